// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequencing front end for a 4-bit combinational ALU.
// Takes one request at a time over valid/ready and evaluates its condition
// code against the flag register. If the condition holds, the operands are
// driven onto the ALU for HOLD_CYCLES cycles. The result and flags are then
// captured and returned over a valid/ready response channel.
module alu_seq_ctrl #(
    parameter int unsigned HOLD_CYCLES = 1  // legal 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    input  logic [1:0] req_op,
    input  logic [2:0] req_cond,
    input  logic       req_setf,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_sel,
    input  logic [3:0] alu_result,
    input  logic [3:0] alu_nzcv,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic [3:0] rsp_nzcv,
    output logic       rsp_skipped,
    output logic [3:0] flags
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    // Condition codes
    localparam logic [2:0] C_AL = 3'd0;
    localparam logic [2:0] C_EQ = 3'd1;
    localparam logic [2:0] C_NE = 3'd2;
    localparam logic [2:0] C_CS = 3'd3;
    localparam logic [2:0] C_CC = 3'd4;
    localparam logic [2:0] C_MI = 3'd5;
    localparam logic [2:0] C_PL = 3'd6;
    localparam logic [2:0] C_VS = 3'd7;

    logic [1:0] state;
    logic [3:0] cnt;
    logic       setf_q;
    logic       cond_ok;

    // Flag register layout is {N,Z,C,V}.
    logic flag_n, flag_z, flag_c, flag_v;
    assign {flag_n, flag_z, flag_c, flag_v} = flags;

    // Handshake outputs are decoded directly from the state register.
    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);

    // Evaluate the request's condition against the flags as they stand at
    // acceptance. A write by the previous op has already landed by then.
    always_comb begin
        // NOTE: default first so no path through the case leaves cond_ok unassigned (no latch).
        cond_ok = 1'b0;
        case (req_cond)
            C_AL:    cond_ok = 1'b1;
            C_EQ:    cond_ok = flag_z;
            C_NE:    cond_ok = !flag_z;
            C_CS:    cond_ok = flag_c;
            C_CC:    cond_ok = !flag_c;
            C_MI:    cond_ok = flag_n;
            C_PL:    cond_ok = !flag_n;
            C_VS:    cond_ok = flag_v;
            default: cond_ok = 1'b0;
        endcase
    end

    // Control FSM with operand, response and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register, including the datapath latches, is reset so outputs read 0 out of reset.
            state       <= S_IDLE;
            cnt         <= 4'd0;
            setf_q      <= 1'b0;
            alu_a       <= 4'd0;
            alu_b       <= 4'd0;
            alu_sel     <= 2'd0;
            rsp_result  <= 4'd0;
            rsp_nzcv    <= 4'd0;
            rsp_skipped <= 1'b0;
            flags       <= 4'd0;
        end else begin
            // NOTE: non-blocking throughout, so every branch reads pre-edge values.
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        setf_q <= req_setf;
                        if (cond_ok) begin
                            alu_a   <= req_a;
                            alu_b   <= req_b;
                            alu_sel <= req_op;
                            cnt     <= HOLD_LOAD;
                            state   <= S_ISSUE;
                        end else begin
                            // Skipped ops leave the ALU inputs and flags untouched.
                            rsp_result  <= 4'd0;
                            rsp_nzcv    <= flags;
                            rsp_skipped <= 1'b1;
                            state       <= S_RESP;
                        end
                    end
                end
                S_ISSUE: begin
                    if (cnt == 4'd0) begin
                        rsp_result  <= alu_result;
                        rsp_nzcv    <= alu_nzcv;
                        rsp_skipped <= 1'b0;
                        if (setf_q) begin
                            flags <= alu_nzcv;
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    // A pending request waits for the next edge; there is no bypass.
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed bench for alu_seq_ctrl.
// Three instances share the request data and reset: u=0 has HOLD=3, u=1 has
// HOLD=1 and u=2 has HOLD=15. Each instance has its own req_valid, rsp_ready
// and a behavioural ALU model.
module tb_alu_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] req_a = '0;
    logic [3:0] req_b = '0;
    logic [1:0] req_op = '0;
    logic [2:0] req_cond = '0;
    logic       req_setf = 1'b0;

    logic [2:0] req_valid_v = '0;
    logic [2:0] rsp_ready_v = '0;
    logic [2:0] req_ready_v;
    logic [2:0] rsp_valid_v;
    logic [2:0] rsp_skipped_v;
    logic [2:0][3:0] alu_a_v;
    logic [2:0][3:0] alu_b_v;
    logic [2:0][1:0] alu_sel_v;
    logic [2:0][3:0] alu_res_v;
    logic [2:0][3:0] alu_nzcv_v;
    logic [2:0][3:0] rsp_result_v;
    logic [2:0][3:0] rsp_nzcv_v;
    logic [2:0][3:0] flags_v;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    // Behavioural ALU. SUB reports C as borrow. AND and OR clear C and V.
    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] s);
        logic [4:0] w;
        logic [3:0] r;
        logic       c;
        logic       v;
        w = '0;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (s)
            2'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[3:0];
                c = w[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            2'd1: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[3:0];
                c = w[4];
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            2'd2: r = a & b;
            default: r = a | b;
        endcase
        return {r, r[3], (r == 4'd0), c, v};
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_alu
        assign {alu_res_v[i], alu_nzcv_v[i]} = alu_f(alu_a_v[i], alu_b_v[i], alu_sel_v[i]);
    end

    alu_seq_ctrl #(.HOLD_CYCLES(3)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_cond(req_cond), .req_setf(req_setf),
        .alu_a(alu_a_v[0]), .alu_b(alu_b_v[0]), .alu_sel(alu_sel_v[0]),
        .alu_result(alu_res_v[0]), .alu_nzcv(alu_nzcv_v[0]),
        .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready_v[0]),
        .rsp_result(rsp_result_v[0]), .rsp_nzcv(rsp_nzcv_v[0]),
        .rsp_skipped(rsp_skipped_v[0]), .flags(flags_v[0])
    );

    alu_seq_ctrl #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_cond(req_cond), .req_setf(req_setf),
        .alu_a(alu_a_v[1]), .alu_b(alu_b_v[1]), .alu_sel(alu_sel_v[1]),
        .alu_result(alu_res_v[1]), .alu_nzcv(alu_nzcv_v[1]),
        .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready_v[1]),
        .rsp_result(rsp_result_v[1]), .rsp_nzcv(rsp_nzcv_v[1]),
        .rsp_skipped(rsp_skipped_v[1]), .flags(flags_v[1])
    );

    alu_seq_ctrl #(.HOLD_CYCLES(15)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_v[2]), .req_ready(req_ready_v[2]),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_cond(req_cond), .req_setf(req_setf),
        .alu_a(alu_a_v[2]), .alu_b(alu_b_v[2]), .alu_sel(alu_sel_v[2]),
        .alu_result(alu_res_v[2]), .alu_nzcv(alu_nzcv_v[2]),
        .rsp_valid(rsp_valid_v[2]), .rsp_ready(rsp_ready_v[2]),
        .rsp_result(rsp_result_v[2]), .rsp_nzcv(rsp_nzcv_v[2]),
        .rsp_skipped(rsp_skipped_v[2]), .flags(flags_v[2])
    );

    // Runs one request on instance u and acknowledges its response. It is
    // entered and left 1 time unit after a rising edge. lat counts edges from
    // acceptance to the first sample showing rsp_valid, or is -1 on timeout.
    // stable goes low if alu_* leave the issued values while waiting.
    task automatic run_op(input int u, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] op, input logic [2:0] cond, input logic setf,
                          output int lat, output logic [3:0] res, output logic [3:0] nzcv,
                          output logic skp, output logic stable);
        int k;
        req_a = a;
        req_b = b;
        req_op = op;
        req_cond = cond;
        req_setf = setf;
        req_valid_v[u] = 1'b1;
        lat = -1;
        stable = 1'b1;
        k = 0;
        while (!req_ready_v[u] && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        req_valid_v[u] = 1'b0;
        for (k = 0; k < 40; k++) begin
            if (rsp_valid_v[u]) begin
                lat = k;
                break;
            end
            if (alu_a_v[u] !== a || alu_b_v[u] !== b || alu_sel_v[u] !== op) stable = 1'b0;
            @(posedge clk); #1;
        end
        res = rsp_result_v[u];
        nzcv = rsp_nzcv_v[u];
        skp = rsp_skipped_v[u];
        rsp_ready_v[u] = 1'b1;
        @(posedge clk); #1;
        rsp_ready_v[u] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (req_ready_v !== 3'b111) begin
            n_mis++;
            $display("FAIL reset_req_ready got=%b want=111", req_ready_v);
        end
        n_cmp++;
        if (rsp_valid_v !== 3'b000 || rsp_skipped_v !== 3'b000) begin
            n_mis++;
            $display("FAIL reset_rsp got valid=%b skip=%b want 000", rsp_valid_v, rsp_skipped_v);
        end
        n_cmp++;
        if (flags_v !== '0 || alu_a_v !== '0 || alu_b_v !== '0 || alu_sel_v !== '0 || rsp_result_v !== '0 || rsp_nzcv_v !== '0) begin
            n_mis++;
            $display("FAIL reset_data got flags=%h alu_a=%h rsp=%h want 0", flags_v, alu_a_v, rsp_result_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int lat;
        logic [3:0] res, nzcv;
        logic skp, st;
        run_op(0, 4'd7, 4'd1, 2'd0, 3'd0, 1'b1, lat, res, nzcv, skp, st);
        n_cmp++;
        if (res !== 4'd8) begin n_mis++; $display("FAIL add_result got=%h want=8", res); end
        n_cmp++;
        if (nzcv !== 4'b1001) begin n_mis++; $display("FAIL add_nzcv got=%b want=1001", nzcv); end
        n_cmp++;
        if (flags_v[0] !== 4'b1001) begin n_mis++; $display("FAIL add_flags got=%b want=1001", flags_v[0]); end
        n_cmp++;
        if (lat !== 3) begin n_mis++; $display("FAIL add_latency got=%0d want=3", lat); end
        n_cmp++;
        if (skp !== 1'b0 || st !== 1'b1) begin n_mis++; $display("FAIL add_skip_stable got skp=%b st=%b want 0/1", skp, st); end
    endtask

    task automatic test_reset_mid_issue();
        int k;
        logic seen;
        req_a = 4'd1;
        req_b = 4'd2;
        req_op = 2'd0;
        req_cond = 3'd0;
        req_setf = 1'b1;
        req_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        req_valid_v[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (alu_a_v[0] !== 4'd0 || alu_b_v[0] !== 4'd0 || alu_sel_v[0] !== 2'd0) begin
            n_mis++;
            $display("FAIL rst_mid_alu got a=%h b=%h sel=%h want 0", alu_a_v[0], alu_b_v[0], alu_sel_v[0]);
        end
        n_cmp++;
        if (flags_v[0] !== 4'd0 || rsp_valid_v[0] !== 1'b0 || rsp_result_v[0] !== 4'd0 || rsp_nzcv_v[0] !== 4'd0) begin
            n_mis++;
            $display("FAIL rst_mid_out got flags=%b valid=%b res=%h want 0", flags_v[0], rsp_valid_v[0], rsp_result_v[0]);
        end
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (req_ready_v[0] !== 1'b1) begin n_mis++; $display("FAIL rst_mid_ready got=%b want=1", req_ready_v[0]); end
        seen = 1'b0;
        for (k = 0; k < 8; k++) begin
            if (rsp_valid_v[0] !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_mis++; $display("FAIL rst_mid_no_rsp got rsp_valid seen=%b want=0", seen); end
    endtask

    task automatic test_cond();
        int lat;
        logic [3:0] res, nzcv;
        logic skp, st;
        run_op(0, 4'd3, 4'd3, 2'd1, 3'd0, 1'b1, lat, res, nzcv, skp, st);
        n_cmp++;
        if (res !== 4'd0 || nzcv !== 4'b0100) begin n_mis++; $display("FAIL sub_zero got res=%h nzcv=%b want 0/0100", res, nzcv); end
        n_cmp++;
        if (flags_v[0] !== 4'b0100) begin n_mis++; $display("FAIL sub_flags got=%b want=0100", flags_v[0]); end
        run_op(0, 4'hF, 4'hA, 2'd2, 3'd1, 1'b0, lat, res, nzcv, skp, st);
        n_cmp++;
        if (res !== 4'hA || skp !== 1'b0 || lat !== 3) begin
            n_mis++;
            $display("FAIL and_eq got res=%h skp=%b lat=%0d want A/0/3", res, skp, lat);
        end
        run_op(0, 4'h5, 4'h5, 2'd0, 3'd2, 1'b1, lat, res, nzcv, skp, st);
        n_cmp++;
        if (skp !== 1'b1 || res !== 4'd0 || nzcv !== 4'b0100) begin
            n_mis++;
            $display("FAIL ne_skip got skp=%b res=%h nzcv=%b want 1/0/0100", skp, res, nzcv);
        end
        n_cmp++;
        if (lat !== 0) begin n_mis++; $display("FAIL ne_latency got=%0d want=0", lat); end
        n_cmp++;
        if (flags_v[0] !== 4'b0100 || alu_a_v[0] !== 4'hF || alu_b_v[0] !== 4'hA || alu_sel_v[0] !== 2'd2) begin
            n_mis++;
            $display("FAIL ne_unchanged got flags=%b alu_a=%h alu_b=%h sel=%h want 0100/F/A/2",
                     flags_v[0], alu_a_v[0], alu_b_v[0], alu_sel_v[0]);
        end
    endtask

    task automatic test_or_nosetf();
        int lat;
        logic [3:0] res, nzcv;
        logic skp, st;
        run_op(0, 4'h8, 4'h1, 2'd3, 3'd0, 1'b0, lat, res, nzcv, skp, st);
        n_cmp++;
        if (res !== 4'h9 || nzcv !== 4'b1000) begin n_mis++; $display("FAIL or_result got res=%h nzcv=%b want 9/1000", res, nzcv); end
        n_cmp++;
        if (flags_v[0] !== 4'b0100) begin n_mis++; $display("FAIL or_flags_kept got=%b want=0100", flags_v[0]); end
    endtask

    task automatic test_back_to_back();
        int k;
        logic ok;
        req_a = 4'd2;
        req_b = 4'd3;
        req_op = 2'd0;
        req_cond = 3'd0;
        req_setf = 1'b0;
        req_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        // The requester holds the next request from here on.
        req_a = 4'd1;
        req_b = 4'd1;
        k = 0;
        while (!rsp_valid_v[0] && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        n_cmp++;
        if (k !== 3) begin n_mis++; $display("FAIL b2b_latency got=%0d want=3", k); end
        ok = 1'b1;
        for (k = 0; k < 5; k++) begin
            if (rsp_valid_v[0] !== 1'b1 || rsp_result_v[0] !== 4'd5 || rsp_skipped_v[0] !== 1'b0 ||
                req_ready_v[0] !== 1'b0 || alu_a_v[0] !== 4'd2) ok = 1'b0;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (ok !== 1'b1) begin n_mis++; $display("FAIL b2b_stall_stable got ok=%b want=1", ok); end
        rsp_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready_v[0] = 1'b0;
        n_cmp++;
        if (req_ready_v[0] !== 1'b1 || rsp_valid_v[0] !== 1'b0 || alu_a_v[0] !== 4'd2) begin
            n_mis++;
            $display("FAIL b2b_no_bypass got ready=%b valid=%b alu_a=%h want 1/0/2",
                     req_ready_v[0], rsp_valid_v[0], alu_a_v[0]);
        end
        @(posedge clk); #1;
        req_valid_v[0] = 1'b0;
        n_cmp++;
        if (req_ready_v[0] !== 1'b0 || alu_a_v[0] !== 4'd1 || alu_b_v[0] !== 4'd1) begin
            n_mis++;
            $display("FAIL b2b_second_accept got ready=%b alu_a=%h alu_b=%h want 0/1/1",
                     req_ready_v[0], alu_a_v[0], alu_b_v[0]);
        end
        k = 0;
        while (!rsp_valid_v[0] && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        n_cmp++;
        if (rsp_result_v[0] !== 4'd2 || k !== 3) begin
            n_mis++;
            $display("FAIL b2b_second_rsp got res=%h lat=%0d want 2/3", rsp_result_v[0], k);
        end
        rsp_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready_v[0] = 1'b0;
    endtask

    task automatic test_hold_extremes();
        int lat;
        logic [3:0] res, nzcv;
        logic skp, st;
        int hold [3] = '{3, 1, 15};
        for (int u = 1; u < 3; u++) begin
            run_op(u, 4'd5, 4'd6, 2'd0, 3'd0, 1'b1, lat, res, nzcv, skp, st);
            n_cmp++;
            if (res !== 4'hB || nzcv !== 4'b1001 || lat !== hold[u] || st !== 1'b1) begin
                n_mis++;
                $display("FAIL hold%0d_add got res=%h nzcv=%b lat=%0d st=%b want B/1001/%0d/1",
                         hold[u], res, nzcv, lat, st, hold[u]);
            end
            run_op(u, 4'd2, 4'd5, 2'd1, 3'd0, 1'b1, lat, res, nzcv, skp, st);
            n_cmp++;
            if (res !== 4'hD || nzcv !== 4'b1010 || lat !== hold[u] || st !== 1'b1) begin
                n_mis++;
                $display("FAIL hold%0d_sub got res=%h nzcv=%b lat=%0d st=%b want D/1010/%0d/1",
                         hold[u], res, nzcv, lat, st, hold[u]);
            end
            n_cmp++;
            if (flags_v[u] !== 4'b1010 || alu_a_v[u] !== 4'd2 || alu_sel_v[u] !== 2'd1) begin
                n_mis++;
                $display("FAIL hold%0d_after got flags=%b alu_a=%h sel=%h want 1010/2/1",
                         hold[u], flags_v[u], alu_a_v[u], alu_sel_v[u]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_reset_mid_issue();
        test_cond();
        test_or_nosetf();
        test_back_to_back();
        test_hold_extremes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
